deletezero: RTL



---
 rtl/deletezero.sv | 84 ++++++++
 1 files changed

// File: rtl/deletezero.sv
// deletezero: receive-side zero deletion for the RS-485 link; drops each stuffed 0
// that follows RUN_LEN payload 1s and reassembles the MSB-first payload word.
module deletezero #(
    parameter int DATA_W  = 40,
    parameter int RUN_LEN = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sof,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              frame_err,
    output logic              busy
);
    localparam int OW = $clog2(RUN_LEN + 1);
    localparam int PW = $clog2(DATA_W + 1);
    typedef enum logic [1:0] {IDLE, RECV, TAIL} state_t;
    state_t            r_state;
    logic [OW-1:0]     r_ones;
    logic [PW-1:0]     r_pay;
    logic [DATA_W-1:0] r_shift;
    logic              w_recv, w_tail, w_last;
    logic [OW-1:0]     w_ones, w_ones_nx;
    logic [PW-1:0]     w_pay;
    logic [DATA_W-1:0] w_shift_nx;
    // sof restarts the frame with cleared counters, so a same-cycle bit is frame bit 1
    always_comb begin
        w_recv     = sof || r_state == RECV;
        w_tail     = !sof && r_state == TAIL;
        w_ones     = sof ? '0 : r_ones;
        w_pay      = sof ? '0 : r_pay;
        w_ones_nx  = bit_in ? w_ones + OW'(1) : '0;
        w_shift_nx = {r_shift[DATA_W-2:0], bit_in};
        w_last     = w_pay == PW'(DATA_W - 1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ones    <= '0;
            r_pay     <= '0;
            r_shift   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            if (sof) begin
                r_state <= RECV;
                r_ones  <= '0;
                r_pay   <= '0;
            end
            if (bit_valid && w_tail) begin
                r_state   <= IDLE;
                out_valid <= !bit_in;
                frame_err <= bit_in;
                if (!bit_in) out_data <= r_shift;
            end else if (bit_valid && w_recv) begin
                if (w_ones == OW'(RUN_LEN)) begin
                    r_ones <= '0;
                    if (bit_in) begin
                        frame_err <= 1'b1;
                        r_state   <= IDLE;
                    end
                end else begin
                    r_shift <= w_shift_nx;
                    r_pay   <= w_pay + PW'(1);
                    r_ones  <= w_ones_nx;
                    // a final run of RUN_LEN ones still owes a trailing stuffed 0
                    if (w_last && w_ones_nx == OW'(RUN_LEN)) begin
                        r_state <= TAIL;
                    end else if (w_last) begin
                        out_data  <= w_shift_nx;
                        out_valid <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
            end
        end
    end
    assign busy = r_state != IDLE;
endmodule
